// File: rtl/fc_loss_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fc_loss_stage_if
// Description : Bundle of signals between the fc layer (forward outputs, backprop
//               error input), the label source and the loss stage.
//               The master side is the fc layer plus the label source.
//               The slave side is the loss stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fc_loss_stage_if #(
  parameter int IDX_W  = 10,
  parameter int DATA_W = 32
) ();

  logic [IDX_W-1:0]  label;
  logic              label_valid;
  logic              out_valid;
  logic [DATA_W-1:0] fc_output;
  logic [IDX_W-1:0]  fc_out_idx;
  logic              out_rdy;
  logic [IDX_W-1:0]  pred_class;
  logic              pred_valid;
  logic              err_valid;
  logic [DATA_W-1:0] err_data;
  logic [IDX_W-1:0]  err_idx;
  logic              err_rdy;
  logic              busy;

  modport master (
    output label, label_valid, out_valid, fc_output, fc_out_idx, err_rdy,
    input  out_rdy, pred_class, pred_valid, err_valid, err_data, err_idx, busy
  );

  modport slave (
    input  label, label_valid, out_valid, fc_output, fc_out_idx, err_rdy,
    output out_rdy, pred_class, pred_valid, err_valid, err_data, err_idx, busy
  );

endinterface
`default_nettype wire

// File: rtl/fc_loss_stage.sv
`default_nettype none
// ============================================================================
// Module      : fc_loss_stage
// Description : Collects the fc forward result vector. Finds the argmax class
//               with a sequential scan. Streams the error vector
//               (output - one-hot target) back to the fc layer with saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_loss_stage #(
  parameter int N_OUT  = 10,
  parameter int IDX_W  = 10,
  parameter int DATA_W = 32,
  parameter int FRAC   = 15
) (
  input wire             clk,
  input wire             rst_n,
  fc_loss_stage_if.slave loss_io
);

  localparam logic [DATA_W-1:0] C_ONE = DATA_W'(1) << FRAC;
  localparam logic [DATA_W-1:0] C_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] C_MAX = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic [1:0] {
    S_COLLECT    = 2'd0,
    S_SCAN       = 2'd1,
    S_WAIT_LABEL = 2'd2,
    S_SEND       = 2'd3
  } state_t;

  state_t            state_q, state_d;

  logic [DATA_W-1:0] mem_q [N_OUT];
  logic [N_OUT-1:0]  mask_q;
  logic [IDX_W-1:0]  label_q;
  logic              label_held_q;

  logic [DATA_W-1:0] max_q;
  logic [IDX_W-1:0]  max_idx_q;
  logic [IDX_W-1:0]  scan_idx_q;
  logic [IDX_W-1:0]  pred_class_q;
  logic              pred_valid_q;

  logic              err_valid_q;
  logic [DATA_W-1:0] err_data_q;
  logic [IDX_W-1:0]  err_idx_q;

  // Combinational helpers
  logic              w_fwd_ok;
  logic [N_OUT-1:0]  w_wr_hit;
  logic [N_OUT-1:0]  w_mask_next;
  logic              w_label_acc;
  logic              w_scan_done;
  logic [DATA_W-1:0] w_scan_val;
  logic [IDX_W-1:0]  w_send_idx;
  logic [DATA_W-1:0] w_send_val;
  logic              w_send_fire;
  logic              w_send_last;
  logic              w_send_load;
  logic [DATA_W-1:0] w_target;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_err_sat;

  // Forward outputs are only taken in COLLECT, so out_rdy is the state decode.
  assign w_fwd_ok = loss_io.out_valid && (state_q == S_COLLECT) &&
                    (loss_io.fc_out_idx < IDX_W'(N_OUT));

  assign w_mask_next = mask_q | w_wr_hit;

  assign w_label_acc = loss_io.label_valid &&
                       ((state_q == S_COLLECT) || (state_q == S_WAIT_LABEL));

  // The scan counter runs one step past the last element.
  // That extra step publishes the result.
  assign w_scan_done = (scan_idx_q == IDX_W'(N_OUT));

  // The first element is loaded on entry to SEND. Each later handshake loads the next one.
  assign w_send_idx  = err_valid_q ? (err_idx_q + IDX_W'(1)) : '0;
  assign w_send_fire = err_valid_q && loss_io.err_rdy;
  assign w_send_last = w_send_fire && (err_idx_q == IDX_W'(N_OUT - 1));
  assign w_send_load = (state_q == S_SEND) &&
                       (!err_valid_q || (w_send_fire && !w_send_last));

  // Subtract the one-hot target with one guard bit.
  // A sign mismatch in the top two bits means overflow.
  assign w_target  = (w_send_idx == label_q) ? C_ONE : '0;
  assign w_diff    = {w_send_val[DATA_W-1], w_send_val} - {1'b0, w_target};
  assign w_err_sat = (w_diff[DATA_W] != w_diff[DATA_W-1])
                   ? (w_diff[DATA_W] ? C_MIN : C_MAX)
                   : w_diff[DATA_W-1:0];

  // Per-element write decode and storage. A duplicate index simply overwrites.
  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_mem
      assign w_wr_hit[gi] = w_fwd_ok && (loss_io.fc_out_idx == IDX_W'(gi));

      // Store the forward value for this neuron index
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_q[gi] <= '0;
        end else if (w_wr_hit[gi]) begin
          mem_q[gi] <= loss_io.fc_output;
        end
      end
    end
  endgenerate

  // Read muxes for the scan pointer and the send pointer
  always_comb begin
    w_scan_val = '0;
    w_send_val = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (scan_idx_q == IDX_W'(k)) w_scan_val = mem_q[k];
      if (w_send_idx == IDX_W'(k)) w_send_val = mem_q[k];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COLLECT: begin
        if (&w_mask_next) state_d = S_SCAN;
      end
      S_SCAN: begin
        if (w_scan_done) state_d = label_held_q ? S_SEND : S_WAIT_LABEL;
      end
      S_WAIT_LABEL: begin
        if (loss_io.label_valid) state_d = S_SEND;
      end
      S_SEND: begin
        if (w_send_last) state_d = S_COLLECT;
      end
      default: state_d = S_COLLECT;
    endcase
  end

  // Received-element mask and label latch. Both clear when the error stream completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q       <= '0;
      label_q      <= '0;
      label_held_q <= 1'b0;
    end else begin
      if (w_send_last) begin
        mask_q <= '0;
      end else begin
        mask_q <= w_mask_next;
      end
      if (w_label_acc) begin
        label_q      <= loss_io.label;
        label_held_q <= 1'b1;
      end else if (w_send_last) begin
        label_held_q <= 1'b0;
      end
    end
  end

  // Sequential argmax: strict signed greater-than keeps the lowest index on ties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q        <= C_MIN;
      max_idx_q    <= '0;
      scan_idx_q   <= '0;
      pred_class_q <= '0;
      pred_valid_q <= 1'b0;
    end else begin
      pred_valid_q <= 1'b0;
      if (state_q == S_COLLECT) begin
        max_q      <= C_MIN;
        max_idx_q  <= '0;
        scan_idx_q <= '0;
      end else if (state_q == S_SCAN) begin
        if (w_scan_done) begin
          pred_class_q <= max_idx_q;
          pred_valid_q <= 1'b1;
        end else begin
          if ($signed(w_scan_val) > $signed(max_q)) begin
            max_q     <= w_scan_val;
            max_idx_q <= scan_idx_q;
          end
          scan_idx_q <= scan_idx_q + IDX_W'(1);
        end
      end
    end
  end

  // Error stream output register. Data holds while err_rdy is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid_q <= 1'b0;
      err_data_q  <= '0;
      err_idx_q   <= '0;
    end else if (w_send_load) begin
      err_valid_q <= 1'b1;
      err_data_q  <= w_err_sat;
      err_idx_q   <= w_send_idx;
    end else if (w_send_last) begin
      err_valid_q <= 1'b0;
    end
  end

  assign loss_io.out_rdy    = (state_q == S_COLLECT);
  assign loss_io.busy       = !((state_q == S_COLLECT) && (mask_q == '0));
  assign loss_io.pred_class = pred_class_q;
  assign loss_io.pred_valid = pred_valid_q;
  assign loss_io.err_valid  = err_valid_q;
  assign loss_io.err_data   = err_data_q;
  assign loss_io.err_idx    = err_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_loss_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc_loss_stage
// Description : Directed self-checking bench for fc_loss_stage
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_loss_stage;

  localparam int N = 10;

  logic clk;
  logic rst_n;

  int n_tests;
  int n_fail;

  logic [31:0] vals  [N];
  logic [31:0] exp_v [N];

  fc_loss_stage_if #(.IDX_W(10), .DATA_W(32)) bus ();

  fc_loss_stage #(
    .N_OUT (10),
    .IDX_W (10),
    .DATA_W(32),
    .FRAC  (15)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .loss_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_out(input logic [9:0] idx, input logic [31:0] val);
    bus.out_valid  = 1'b1;
    bus.fc_out_idx = idx;
    bus.fc_output  = val;
    step();
    bus.out_valid  = 1'b0;
  endtask

  task automatic give_label(input logic [9:0] lbl);
    bus.label       = lbl;
    bus.label_valid = 1'b1;
    step();
    bus.label_valid = 1'b0;
  endtask

  task automatic send_all();
    for (int i = 0; i < N; i++) send_out(10'(i), vals[i]);
  endtask

  task automatic wait_pred(input logic [9:0] cls);
    int w;
    w = 0;
    while (!bus.pred_valid && w < 40) begin
      step();
      w++;
    end
    chk("pred_valid", 32'(bus.pred_valid), 32'd1);
    chk("pred_class", 32'(bus.pred_class), 32'(cls));
  endtask

  // Consume `count` error elements; toggle=1 alternates err_rdy starting low
  task automatic drain(input bit toggle, input int count);
    int w;
    int k;
    int cyc;
    bit rdy;
    w = 0;
    while (!bus.err_valid && w < 40) begin
      step();
      w++;
    end
    chk("err_start", 32'(bus.err_valid), 32'd1);
    k = 0;
    cyc = 0;
    while (k < count && cyc < 100) begin
      rdy = toggle ? ((cyc % 2) == 1) : 1'b1;
      bus.err_rdy = rdy;
      chk("err_valid", 32'(bus.err_valid), 32'd1);
      chk("err_idx", 32'(bus.err_idx), 32'(k));
      chk("err_data", bus.err_data, exp_v[k]);
      step();
      if (rdy) k++;
      cyc++;
    end
    bus.err_rdy = 1'b1;
    chk("err_count", 32'(k), 32'(count));
    if (count == N) begin
      chk("end_err_valid", 32'(bus.err_valid), 32'd0);
      chk("end_out_rdy", 32'(bus.out_rdy), 32'd1);
      chk("end_busy", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n            = 1'b0;
    bus.label        = '0;
    bus.label_valid  = 1'b0;
    bus.out_valid    = 1'b0;
    bus.fc_output    = '0;
    bus.fc_out_idx   = '0;
    bus.err_rdy      = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_out_rdy", 32'(bus.out_rdy), 32'd1);
    chk("rst_pred_valid", 32'(bus.pred_valid), 32'd0);
    chk("rst_err_valid", 32'(bus.err_valid), 32'd0);
    chk("rst_err_data", bus.err_data, 32'd0);
    chk("rst_err_idx", 32'(bus.err_idx), 32'd0);
    chk("rst_pred_class", 32'(bus.pred_class), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    step();

    // Test 1: basic vector, label 2 before first output, exact latency
    vals  = '{32'h0000_4000, 32'hFFFF_8000, 32'h0001_0000, 32'h0000_2000, 32'h0000_6000,
              32'hFFFF_C000, 32'h0000_1000, 32'h0000_0000, 32'h0000_8000, 32'h0000_0000};
    exp_v = '{32'h0000_4000, 32'hFFFF_8000, 32'h0000_8000, 32'h0000_2000, 32'h0000_6000,
              32'hFFFF_C000, 32'h0000_1000, 32'h0000_0000, 32'h0000_8000, 32'h0000_0000};
    give_label(10'd2);
    chk("t1_busy_idle", 32'(bus.busy), 32'd0);
    send_out(10'd0, vals[0]);
    chk("t1_busy_collect", 32'(bus.busy), 32'd1);
    for (int i = 1; i < N; i++) send_out(10'(i), vals[i]);
    chk("t1_out_rdy_scan", 32'(bus.out_rdy), 32'd0);
    for (int i = 0; i < 10; i++) step();
    chk("t1_pred_early", 32'(bus.pred_valid), 32'd0);
    step();
    chk("t1_pred_valid", 32'(bus.pred_valid), 32'd1);
    chk("t1_pred_class", 32'(bus.pred_class), 32'd2);
    chk("t1_err_not_yet", 32'(bus.err_valid), 32'd0);
    step();
    chk("t1_pred_pulse", 32'(bus.pred_valid), 32'd0);
    drain(1'b0, N);

    // Test 2: tie between idx3 and idx7, label overwritten 1 -> 7
    vals  = '{32'h0000_1000, 32'hFFFF_0000, 32'h0000_8000, 32'h0002_0000, 32'h0001_0000,
              32'hFFFF_FFFF, 32'h0001_8000, 32'h0002_0000, 32'h0000_0000, 32'h0001_FFFF};
    exp_v = '{32'h0000_1000, 32'hFFFF_0000, 32'h0000_8000, 32'h0002_0000, 32'h0001_0000,
              32'hFFFF_FFFF, 32'h0001_8000, 32'h0001_8000, 32'h0000_0000, 32'h0001_FFFF};
    give_label(10'd1);
    for (int i = 0; i < 5; i++) send_out(10'(i), vals[i]);
    give_label(10'd7);
    for (int i = 5; i < N; i++) send_out(10'(i), vals[i]);
    wait_pred(10'd3);
    drain(1'b0, N);

    // Test 3: no label; forward traffic ignored while waiting; label 5 late
    vals  = '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000,
              32'h0000_5000, 32'h0000_6000, 32'h0000_7000, 32'h0000_8000, 32'h0000_9000};
    exp_v = '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000,
              32'hFFFF_D000, 32'h0000_6000, 32'h0000_7000, 32'h0000_8000, 32'h0000_9000};
    send_all();
    wait_pred(10'd9);
    bus.out_valid  = 1'b1;
    bus.fc_out_idx = 10'd5;
    bus.fc_output  = 32'h7FFF_FFFF;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t3_wait_out_rdy", 32'(bus.out_rdy), 32'd0);
      chk("t3_wait_err", 32'(bus.err_valid), 32'd0);
    end
    bus.out_valid = 1'b0;
    chk("t3_wait_busy", 32'(bus.busy), 32'd1);
    give_label(10'd5);
    step();
    chk("t3_send_start", 32'(bus.err_valid), 32'd1);
    drain(1'b0, N);

    // Test 4/5: saturation at idx0 with label 0, err_rdy toggling
    vals  = '{32'h8000_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    exp_v = '{32'h8000_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    give_label(10'd0);
    send_all();
    wait_pred(10'd1);
    drain(1'b1, N);

    // Test 6: out-of-order, dropped idx12, duplicate idx4, reset mid-SEND
    exp_v = '{32'h0000_0000, 32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'hFFFF_8000,
              32'h0000_0500, 32'h0000_0600, 32'h0000_0700, 32'h0000_0800, 32'h0000_0900};
    give_label(10'd4);
    send_out(10'd9,  32'h0000_0900);
    send_out(10'd7,  32'h0000_0700);
    send_out(10'd12, 32'h7FFF_FFFF);
    send_out(10'd4,  32'h7FFF_0000);
    send_out(10'd5,  32'h0000_0500);
    send_out(10'd3,  32'h0000_0300);
    send_out(10'd1,  32'h0000_0100);
    send_out(10'd0,  32'h0000_0000);
    send_out(10'd2,  32'h0000_0200);
    send_out(10'd6,  32'h0000_0600);
    send_out(10'd4,  32'h0000_0000);
    step();
    step();
    chk("t6_still_collect", 32'(bus.out_rdy), 32'd1);
    chk("t6_no_pred", 32'(bus.pred_valid), 32'd0);
    send_out(10'd8,  32'h0000_0800);
    wait_pred(10'd9);
    drain(1'b0, 5);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_err_valid", 32'(bus.err_valid), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_post_out_rdy", 32'(bus.out_rdy), 32'd1);
    chk("t6_post_busy", 32'(bus.busy), 32'd0);
    chk("t6_post_err_valid", 32'(bus.err_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fc_loss_stage.md
Name: fc_loss_stage

Overview:
Downstream neighbour of the fc layer. Consumes the N_OUT-element forward result stream (out_valid/fc_output/fc_out_idx) and collects it into a local register file. It then produces the predicted class (argmax) and streams the error vector (output − one-hot target) back to the fc layer for the backprop pass (BP_SEND).

Parameters:
N_OUT, 10, number of fc output neurons / classes
IDX_W, 10, width of index buses (matches fc index ports)
DATA_W, 32, sample width; two's complement, FRAC fractional bits
FRAC, 15, fractional bits; 1.0 = 1<<FRAC = 32'h0000_8000

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
label  in  IDX_W  true class of current image
label_valid  in  1  label strobe; latched when accepted
out_valid  in  1  fc forward output valid
fc_output  in  DATA_W  fc forward output value
fc_out_idx  in  IDX_W  neuron index of fc_output
out_rdy  out  1  ready to accept forward outputs (drives fc out_rdy)
pred_class  out  IDX_W  argmax index
pred_valid  out  1  one-cycle pulse when pred_class is final
err_valid  out  1  error element valid
err_data  out  DATA_W  error value, output − target
err_idx  out  IDX_W  error element index
err_rdy  in  1  fc ready for backprop input
busy  out  1  high in any state other than COLLECT with zero elements received

Behaviour:
- Reset (async, rst_n=0): state=COLLECT; out_rdy=1; pred_valid=0; err_valid=0; err_data=0; err_idx=0; pred_class=0; busy=0; received mask=0; label_held=0; max register=most-negative value.
- Forward transfer: occurs when out_valid && out_rdy on a rising edge. Store fc_output at fc_out_idx and set mask bit.
  - fc_out_idx ≥ N_OUT: drop the transfer; no mask change.
  - Duplicate index: overwrite the stored value. Argmax is recomputed in SCAN, never on the fly.
- Label: accepted when label_valid=1 in COLLECT or WAIT_LABEL. Latch the value and set label_held. A later label_valid before SEND overwrites it. Labels ≥ N_OUT are latched as-is, so the target is all zeros.
- States:
  - COLLECT: out_rdy=1. When the mask reaches all ones (counting the current cycle's transfer), go to SCAN next cycle; out_rdy=0 from that cycle.
  - SCAN: one element per cycle, index 0..N_OUT−1, signed compare. Strict greater-than, so the lowest index wins ties. After the last element: pred_class valid, pred_valid pulses for 1 cycle. Then go to SEND if label_held, else WAIT_LABEL.
  - WAIT_LABEL: out_rdy=0. On label_valid, go to SEND next cycle.
  - SEND: present elements in index order 0..N_OUT−1.
    - err_data = stored − (idx==label ? 1<<FRAC : 0), with signed saturation to [0x8000_0000, 0x7FFF_FFFF].
    - err_valid is held with stable data until err_rdy; advance on err_valid && err_rdy.
    - err_valid stays high back-to-back when err_rdy is held high. Throughput is 1/cycle.
    - After the last handshake: err_valid=0, mask cleared, label_held cleared, go to COLLECT.
- Latency: last forward transfer → pred_valid = N_OUT+1 cycles. First err_valid is the cycle after pred_valid if a label is held.
- out_rdy=0 outside COLLECT. out_valid asserted then is ignored and the data is not stored.
- Reset mid-operation: all state is lost; any in-flight SEND is abandoned and err_valid drops immediately (asynchronously).

Test Plan:
1. Outputs idx 0..9 = {0.5,−1.0,2.0,0.25,…,0} (2.0=0x0001_0000), label=2 given before the first output → pred_class=2 pulse 11 cycles after idx 9. Error stream: idx2 = 0x0000_8000, idx1 = 0xFFFF_8000, others = stored values.
2. Tie: idx3 and idx7 both 0x0002_0000 (max) → pred_class=3.
3. No label until 20 cycles after SCAN → out_rdy stays 0, no err_valid. label_valid=5 → SEND starts next cycle, idx5 error = stored−0x8000.
4. Saturation: idx0 = 0x8000_0000, label=0 → err_data = 0x8000_0000 (not wrapped).
5. err_rdy toggling 1/0 each cycle → err_data/err_idx stable while stalled; exactly 10 transfers in order; returns to COLLECT with out_rdy=1.
6. Out-of-order indices plus idx 12 and a duplicate idx4 (first 0x7FFF_0000, then 0) → idx12 ignored; SCAN only after all 0..9 are seen; idx4 error uses 0. rst_n pulsed mid-SEND → err_valid=0 immediately, out_rdy=1 after release.
